// File: rtl/fma16_pkg.sv
// Shared types for the fma16 request controller: FSM states, op-control
// bits, rounding-mode encodings and exception-flag bit positions.
package fma16_pkg;

   // Controller states (see fma16_ctrl for the state table)
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

   // Op control as presented on req_op / dp_op, msb first
   typedef struct packed {
      logic mul;
      logic add;
      logic negp;
      logic negz;
   } op_ctrl_t;

   // Rounding modes; the controller only forwards these
   typedef enum logic [1:0] {
      RM_RNE = 2'd0,
      RM_RTZ = 2'd1,
      RM_RDN = 2'd2,
      RM_RUP = 2'd3
   } rm_e;

   // Bit positions inside the 4-bit {NV, OF, UF, NX} flag vector
   localparam int unsigned FLAG_NV = 3;
   localparam int unsigned FLAG_OF = 2;
   localparam int unsigned FLAG_UF = 1;
   localparam int unsigned FLAG_NX = 0;

   // Latency down-counter width, enough for LAT up to 15
   localparam int unsigned CNT_W = 4;

   // One-hot requester vector from a requester index
   function automatic logic [1:0] idx_onehot(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/fma16_rrarb.sv
// Two-way round-robin arbiter. A lone request always wins; on contention
// the requester that was not granted last time wins. Purely combinational.
module fma16_rrarb (
   input  logic [1:0] valid,
   input  logic       last,
   output logic [1:0] grant
);

   // Pick the winner; last=1 means requester 1 was served most recently
   always_comb begin
      grant = 2'b00;
      if (valid == 2'b11) begin
         grant = last ? 2'b01 : 2'b10;
      end else begin
         grant = valid;
      end
   end

endmodule

// File: rtl/fma16_ctrl.sv
// Front-end controller sharing one fma16 datapath between two requesters.
// Optional feature: define FMA16_CTRL_STICKY_FLAGS_EN to add per-requester
// sticky exception flags (flag_clr / sticky_flags ports).
//
// state | meaning
// IDLE  | waiting for a request; grants and captures operands
// ISSUE | dp_start pulse, latency counter loaded with LAT-1
// WAIT  | counting down; at zero the datapath result is captured
// RESP  | result held on rsp_* until the owner accepts it
module fma16_ctrl
   import fma16_pkg::*;
#(
   parameter int unsigned LAT = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [1:0][15:0] req_x,
   input  logic [1:0][15:0] req_y,
   input  logic [1:0][15:0] req_z,
   input  logic [1:0][3:0]  req_op,
   input  logic [1:0][1:0]  req_rm,
   output logic [1:0]       rsp_valid,
   input  logic [1:0]       rsp_ready,
   output logic [15:0]      rsp_result,
   output logic [3:0]       rsp_flags,
   output logic [15:0]      dp_x,
   output logic [15:0]      dp_y,
   output logic [15:0]      dp_z,
   output logic [3:0]       dp_op,
   output logic [1:0]       dp_rm,
   output logic             dp_start,
   input  logic [15:0]      dp_result,
   input  logic [3:0]       dp_flags
`ifdef FMA16_CTRL_STICKY_FLAGS_EN
   ,
   input  logic [1:0]       flag_clr,
   output logic [1:0][3:0]  sticky_flags
`endif
);

   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LAT - 1);

   state_e           state_q;
   logic             owner_q;
   logic             last_q;
   logic [CNT_W-1:0] cnt_q;
   logic [15:0]      x_q, y_q, z_q;
   op_ctrl_t         op_q;
   rm_e              rm_q;
   logic             start_q;
   logic [1:0]       rsp_valid_q;
   logic [15:0]      result_q;
   logic [3:0]       flags_q;

   logic [1:0]       grant;
   logic             gnt_idx;
   logic             rsp_hs;

   fma16_rrarb u_arb (
      .valid (req_valid),
      .last  (last_q),
      .grant (grant)
   );

   assign gnt_idx = grant[1];
   assign rsp_hs  = (state_q == ST_RESP) && rsp_ready[owner_q];

   // Accept is only offered in IDLE; gating with reset_n keeps it low while reset is held
   assign req_ready = (reset_n && state_q == ST_IDLE) ? grant : 2'b00;

   assign dp_x       = x_q;
   assign dp_y       = y_q;
   assign dp_z       = z_q;
   assign dp_op      = op_q;
   assign dp_rm      = rm_q;
   assign dp_start   = start_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_result = result_q;
   assign rsp_flags  = flags_q;

   // Main sequencing FSM with all outputs registered
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         owner_q     <= 1'b0;
         last_q      <= 1'b1;
         cnt_q       <= '0;
         x_q         <= '0;
         y_q         <= '0;
         z_q         <= '0;
         op_q        <= '0;
         rm_q        <= RM_RNE;
         start_q     <= 1'b0;
         rsp_valid_q <= 2'b00;
         result_q    <= '0;
         flags_q     <= '0;
      end else begin
         start_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (|req_valid) begin
                  owner_q <= gnt_idx;
                  x_q     <= req_x[gnt_idx];
                  y_q     <= req_y[gnt_idx];
                  z_q     <= req_z[gnt_idx];
                  op_q    <= req_op[gnt_idx];
                  rm_q    <= rm_e'(req_rm[gnt_idx]);
                  start_q <= 1'b1;
                  state_q <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               cnt_q   <= CNT_INIT;
               state_q <= ST_WAIT;
            end
            ST_WAIT: begin
               if (cnt_q == '0) begin
                  result_q    <= dp_result;
                  flags_q     <= dp_flags;
                  rsp_valid_q <= idx_onehot(owner_q);
                  state_q     <= ST_RESP;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            ST_RESP: begin
               if (rsp_hs) begin
                  rsp_valid_q <= 2'b00;
                  last_q      <= owner_q;
                  state_q     <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

`ifdef FMA16_CTRL_STICKY_FLAGS_EN
   logic [1:0][3:0] sticky_q;

   assign sticky_flags = sticky_q;

   // Accumulate flags per owner on handshake; a clear in the same cycle keeps only the new flags
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sticky_q <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (flag_clr[i]) begin
               sticky_q[i] <= (rsp_hs && owner_q == 1'(i)) ? flags_q : 4'b0000;
            end else if (rsp_hs && owner_q == 1'(i)) begin
               sticky_q[i] <= sticky_q[i] | flags_q;
            end
         end
      end
   end
`endif

endmodule

// File: doc/fma16_ctrl.md
FMA16_CTRL -- requirements
Module: fma16_ctrl

Interface
REQ-001 Parameter LAT, default 2, datapath latency in cycles from dp_start to valid dp_result; legal range 1..15.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  2  per-requester operation request.
REQ-005 req_ready  output  2  per-requester accept; handshake = valid & ready.
REQ-006 req_x, req_y, req_z  input  2x16 each  per-requester half-precision operands.
REQ-007 req_op  input  2x4  per-requester op control {mul, add, negp, negz}.
REQ-008 req_rm  input  2x2  per-requester rounding mode, forwarded to the datapath uninterpreted.
REQ-009 rsp_valid  output  2  per-requester result valid; at most one bit set.
REQ-010 rsp_ready  input  2  per-requester result accept.
REQ-011 rsp_result  output  16  result, shared by both requesters; qualified by rsp_valid.
REQ-012 rsp_flags  output  4  {NV, OF, UF, NX}, shared; qualified by rsp_valid.
REQ-013 dp_x, dp_y, dp_z  output  16 each  operands to the shared fma16 datapath.
REQ-014 dp_op  output  4; dp_rm  output  2  datapath controls.
REQ-015 dp_start  output  1  one-cycle launch pulse.
REQ-016 dp_result  input  16; dp_flags  input  4  datapath outputs, valid LAT cycles after dp_start.

Function
REQ-017 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-018 IDLE: if any req_valid, grant one, assert req_ready for the granted requester only (combinational, same cycle), capture its operands/op/rm and the owner index, go to ISSUE.
REQ-019 Arbitration: single valid wins; both valid -> requester not granted last wins (round-robin).
REQ-020 ISSUE: dp_start=1 for exactly one cycle, counter loaded with LAT-1, go to WAIT.
REQ-021 WAIT: counter decrements; at 0, capture dp_result/dp_flags into registers and go to RESP.
REQ-022 dp_x/y/z, dp_op, dp_rm driven from captured registers, stable from ISSUE through end of WAIT.
REQ-023 RESP: rsp_valid[owner]=1 with registered result/flags, held stable until rsp_ready[owner]; on handshake, update last-grant to owner and return to IDLE.
REQ-024 No new grant in the RESP handshake cycle; minimum issue interval LAT+3 cycles.
REQ-025 req_ready is 0 in all states except IDLE; req_valid withdrawn before grant is legal and ignored.
REQ-026 rsp_ready for the non-owner, and rsp_ready outside RESP, are ignored.

Reset
REQ-027 reset_n low, any state, asynchronously: state=IDLE, req_ready=0, rsp_valid=0, dp_start=0, rsp_result=0, rsp_flags=0, dp_* outputs=0, counter=0, last-grant=1 (requester 0 wins first contention).
REQ-028 An operation in flight at reset is discarded; no response is produced.

Configuration
REQ-029 Macro FMA16_CTRL_STICKY_FLAGS_EN defined: add ports flag_clr input 2 and sticky_flags output 2x4; on each RESP handshake OR rsp_flags into sticky_flags[owner]; flag_clr[i] clears entry i; clear and set in the same cycle yields the new flags only; reset value 0.
REQ-030 Macro undefined: the flag_clr and sticky_flags ports and their registers do not exist; all other behaviour is identical.

Structure
REQ-031 Package fma16_pkg holds: state enum, op-control struct {mul, add, negp, negz}, rounding-mode typedef with named encodings, flag bit-index constants.
REQ-032 Sub-module fma16_rrarb: 2-way round-robin arbiter (inputs: valid[1:0], last; output: one-hot grant), purely combinational.

Verification
REQ-033 Single request, LAT=2: req_valid=01, x=3C00, y=4000, z=0000 -> req_ready=01 in cycle 0, dp_start in cycle 1, rsp_valid=01 in cycle 4 with dp_result echoed.
REQ-034 Contention: both valid continuously for 4 operations after reset -> grant order 0,1,0,1.
REQ-035 Backpressure: hold rsp_ready=00 for 10 cycles in RESP -> rsp_result/rsp_flags stable, req_ready=00 throughout.
REQ-036 Reset asserted in WAIT -> all outputs 0 immediately; no rsp_valid after release; next contention grants requester 0.
REQ-037 LAT=1 and LAT=15 builds: rsp_valid exactly LAT+2 cycles after grant.
REQ-038 With FMA16_CTRL_STICKY_FLAGS_EN: responses flags 0001 then 0100 to requester 1 -> sticky_flags[1]=0101; flag_clr=10 coincident with a third response flags 0010 -> 0010.
